// File: rtl/cdc_bus_pkg.sv
// Shared types and limits for the req/ack bus crossing (receiver and matching sender).
package cdc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

  function automatic bit sync_stages_ok(input int n);
    return (n >= SYNC_MIN) && (n <= SYNC_MAX);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Level synchronizer: STAGES flops, async active-high reset to 0; o_q is the last stage.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_bus_rx.sv
// Destination end of the four-phase req/ack word crossing: synchronizes req, captures
// the source-held word, offers it with valid/ready and returns a registered ack level.
module cdc_bus_rx
  import cdc_bus_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              des_clk,
  input  logic              des_rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_data,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_xfer_cnt
);

  generate
    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
      $error("cdc_bus_rx: SYNC_STAGES must be within SYNC_MIN..SYNC_MAX");
    end
  endgenerate

  logic              w_req_s;
  state_e            r_state;
  logic              r_viol;
  logic              r_ack;
  logic              r_vld;
  logic              r_err;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .i_clk (des_clk),
    .i_rst (des_rst),
    .i_d   (i_req),
    .o_q   (w_req_s)
  );

  // i_data is only sampled in IDLE with req_s high: the source holds it stable by then.
  always_ff @(posedge des_clk or posedge des_rst) begin
    if (des_rst) begin
      r_state <= ST_IDLE;
      r_viol  <= 1'b0;
      r_ack   <= 1'b0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_s) begin
            r_data  <= i_data;
            r_vld   <= 1'b1;
            r_viol  <= 1'b0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Early req drop is flagged once per transfer; the word is still delivered.
          if (!w_req_s && !r_viol) begin
            r_err  <= 1'b1;
            r_viol <= 1'b1;
          end
          if (r_vld && i_rdy) begin
            r_vld   <= 1'b0;
            r_ack   <= 1'b1;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!w_req_s) begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_vld   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ack      = r_ack;
  assign o_data     = r_data;
  assign o_vld      = r_vld;
  assign o_err      = r_err;
  assign o_xfer_cnt = r_cnt;

endmodule

// File: tb/tb_cdc_bus_rx.sv
// Self-checking bench for cdc_bus_rx: directed vector table, corner sequences, and a
// randomized run against a transfer-level reference model.
module tb_cdc_bus_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_a, rdy_a;
  logic [7:0] din_a;
  logic       ack_a, vld_a, err_a;
  logic [7:0] dout_a, cnt_a;

  logic       req_b, rdy_b;
  logic [7:0] din_b;
  logic       ack_b, vld_b, err_b;
  logic [7:0] dout_b;
  logic [1:0] cnt_b;

  cdc_bus_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(8)) dut_a (
    .des_clk    (clk),
    .des_rst    (rst),
    .i_req      (req_a),
    .i_data     (din_a),
    .o_ack      (ack_a),
    .o_data     (dout_a),
    .o_vld      (vld_a),
    .i_rdy      (rdy_a),
    .o_err      (err_a),
    .o_xfer_cnt (cnt_a)
  );

  cdc_bus_rx #(.DATA_W(8), .SYNC_STAGES(4), .CNT_W(2)) dut_b (
    .des_clk    (clk),
    .des_rst    (rst),
    .i_req      (req_b),
    .i_data     (din_b),
    .o_ack      (ack_b),
    .o_data     (dout_b),
    .o_vld      (vld_b),
    .i_rdy      (rdy_b),
    .o_err      (err_b),
    .o_xfer_cnt (cnt_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       rdy;
    logic       vld;
    logic       ack;
    logic [7:0] dout;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[8];

  // Reference model: requests become visible SYNC_STAGES edges late; the receiver is
  // either empty, offering a word, or acknowledging (identified by m_vld / m_ack).
  localparam int MS = 2;
  bit         q[$];
  bit         m_vld, m_ack, m_err, m_viol;
  logic [7:0] m_data, m_cnt;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < MS; i++) q.push_back(1'b0);
    m_vld = 0; m_ack = 0; m_err = 0; m_viol = 0;
    m_data = 8'h00; m_cnt = 8'h00;
  endtask

  task automatic model_step(input bit req, input logic [7:0] d, input bit rdy);
    bit seen;
    seen = q.pop_back();
    q.push_front(req);
    m_err = 0;
    if (m_ack) begin
      if (!seen) m_ack = 0;
    end else if (m_vld) begin
      if (!seen && !m_viol) begin
        m_err  = 1;
        m_viol = 1;
      end
      if (rdy) begin
        m_vld = 0;
        m_ack = 1;
        m_cnt = m_cnt + 8'd1;
      end
    end else if (seen) begin
      m_vld  = 1;
      m_data = d;
      m_viol = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  lat, errs;
    bit  seen;
    bit  prev_ack;
    logic [7:0] d;

    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
    tbl[1] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0};
    tbl[2] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 8'd0};
    tbl[3] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 8'd1};
    tbl[4] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 8'd1};
    tbl[5] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 8'd1};
    tbl[6] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 8'd1};
    tbl[7] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 8'd1};

    rst = 1'b1;
    req_a = 0; rdy_a = 0; din_a = 8'h00;
    req_b = 0; rdy_b = 1; din_b = 8'h00;
    repeat (3) tick();
    chk("reset_ack", ack_a, 0);
    chk("reset_vld", vld_a, 0);
    chk("reset_data", dout_a, 8'h00);
    chk("reset_err", err_a, 0);
    chk("reset_cnt", cnt_a, 0);
    chk("reset_cnt_b", cnt_b, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      req_a = tbl[i].req; din_a = tbl[i].data; rdy_a = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_vld", i), vld_a, tbl[i].vld);
      chk($sformatf("tbl%0d_ack", i), ack_a, tbl[i].ack);
      chk($sformatf("tbl%0d_data", i), dout_a, tbl[i].dout);
      chk($sformatf("tbl%0d_err", i), err_a, 0);
      chk($sformatf("tbl%0d_cnt", i), cnt_a, tbl[i].cnt);
    end
    $display("xfer single: data=%02h cnt=%0d", dout_a, cnt_a);

    // Back-pressure: word and valid must hold while downstream stalls.
    req_a = 1; din_a = 8'hA5; rdy_a = 0;
    repeat (3) tick();
    chk("bp_vld_rise", vld_a, 1);
    chk("bp_data", dout_a, 8'hA5);
    din_a = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_vld", vld_a, 1);
      chk("bp_hold_data", dout_a, 8'hA5);
      chk("bp_no_ack", ack_a, 0);
    end
    rdy_a = 1;
    tick();
    chk("bp_ack", ack_a, 1);
    chk("bp_vld_fall", vld_a, 0);
    chk("bp_cnt", cnt_a, 2);
    req_a = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (!ack_a) seen = 1;
    end
    chk("bp_ack_drop", seen, 1);
    $display("xfer backpressure: data=%02h cnt=%0d", dout_a, cnt_a);

    // Protocol violation: req dropped while the word is still offered.
    rdy_a = 0; req_a = 1; din_a = 8'h5A;
    repeat (3) tick();
    chk("viol_vld", vld_a, 1);
    req_a = 0;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      errs += int'(err_a);
    end
    chk("viol_err_pulses", errs, 1);
    chk("viol_vld_held", vld_a, 1);
    rdy_a = 1;
    tick();
    chk("viol_ack", ack_a, 1);
    chk("viol_vld_fall", vld_a, 0);
    chk("viol_cnt", cnt_a, 3);
    chk("viol_err_quiet", err_a, 0);
    tick();
    chk("viol_idle_ack", ack_a, 0);
    tick();
    chk("viol_idle_vld", vld_a, 0);
    $display("xfer violation: data=%02h cnt=%0d err_pulses=%0d", dout_a, cnt_a, errs);

    // Reset while acknowledging with req still high.
    req_a = 1; din_a = 8'hC3; rdy_a = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (ack_a) seen = 1;
    end
    chk("rst_reach_ack", seen, 1);
    rst = 1'b1;
    #1;
    chk("rst_ack_now", ack_a, 0);
    chk("rst_vld_now", vld_a, 0);
    chk("rst_cnt_now", cnt_a, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("rst_relaunch_vld_e%0d", k), vld_a, (k == 3) ? 1 : 0);
    end
    chk("rst_recapture", dout_a, 8'hC3);
    tick();
    chk("rst_ack2", ack_a, 1);
    chk("rst_cnt2", cnt_a, 1);
    req_a = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (!ack_a) seen = 1;
    end
    chk("rst_ack2_drop", seen, 1);
    $display("xfer after reset: data=%02h cnt=%0d", dout_a, cnt_a);

    // Four-stage synchronizer latency and two-bit counter wrap.
    for (int t = 0; t < 5; t++) begin
      d = 8'($urandom);
      req_b = 1; din_b = d;
      lat = 0;
      seen = 0;
      while (!seen && lat < 20) begin
        tick();
        lat++;
        if (vld_b) seen = 1;
      end
      chk("b_latency", lat, 5);
      chk("b_data", dout_b, d);
      tick();
      chk("b_ack", ack_b, 1);
      chk("b_cnt", cnt_b, (t + 1) % 4);
      req_b = 0;
      seen = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
        tick();
        if (!ack_b) seen = 1;
      end
      chk("b_ack_drop", seen, 1);
      chk("b_err", err_b, 0);
      $display("xfer b%0d: data=%02h cnt=%0d latency=%0d", t, dout_b, cnt_b, lat);
    end

    // Randomized run against the reference model.
    req_a = 0; rdy_a = 0; din_a = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    prev_ack = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      model_step(req_a, din_a, rdy_a);
      chk("rnd_vld", vld_a, m_vld);
      chk("rnd_ack", ack_a, m_ack);
      chk("rnd_data", dout_a, m_data);
      chk("rnd_err", err_a, m_err);
      chk("rnd_cnt", cnt_a, m_cnt);
      if (m_ack && !prev_ack) $display("xfer rnd: cycle=%0d data=%02h cnt=%0d", c, m_data, m_cnt);
      prev_ack = m_ack;
      if ($urandom_range(0, 5) == 0) req_a = ~req_a;
      din_a = 8'($urandom);
      rdy_a = 1'($urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
